// File: rtl/rv32_wb_timer.sv
`default_nettype none
// rv32_wb_timer: Wishbone-classic responder holding a 64-bit mtime/mtimecmp pair
// with a prescaled tick and a level compare interrupt.  Revision: 1.0
module rv32_wb_timer #(
   parameter int PRESCALE_DIV = 50
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        timer_irq_o
);

   localparam logic [0:0]  S_IDLE     = 1'b0;
   localparam logic [0:0]  S_ACK      = 1'b1;
   localparam logic [15:0] PRE_LAST   = 16'(PRESCALE_DIV - 1);
   localparam logic [2:0]  A_MTIME_LO = 3'd0;
   localparam logic [2:0]  A_MTIME_HI = 3'd1;
   localparam logic [2:0]  A_CMP_LO   = 3'd2;
   localparam logic [2:0]  A_CMP_HI   = 3'd3;
   localparam logic [2:0]  A_CTRL     = 3'd4;
   localparam logic [2:0]  A_STATUS   = 3'd5;

   logic [0:0]  state_q, state_d;
   logic [63:0] mtime_q, mtime_d;
   logic [63:0] cmp_q, cmp_d;
   logic        en_q, en_d;
   logic        ie_q, ie_d;
   logic [15:0] pre_q, pre_d;
   logic [31:0] shadow_q, shadow_d;
   logic [31:0] dat_q, dat_d;
   logic        irq_q, irq_d;

   logic        accept, wr_en, rd_en, tick, stop, ge;
   logic [2:0]  addr;
   logic        unused_adr;

   assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
      end
      return r;
   endfunction

   always_comb begin
      accept = wb_cyc_i & wb_stb_i & (state_q == S_IDLE);
      wr_en  = accept & wb_we_i;
      rd_en  = accept & ~wb_we_i;
      addr   = wb_adr_i[4:2];
      ge     = (mtime_q >= cmp_q);
      tick   = en_q & (pre_q == PRE_LAST);
      // A CTRL write that clears EN freezes counting at its own edge.
      stop   = wr_en & (addr == A_CTRL) & wb_sel_i[0] & ~wb_dat_i[0];

      state_d  = accept ? S_ACK : S_IDLE;
      en_d     = en_q;
      ie_d     = ie_q;
      cmp_d    = cmp_q;
      shadow_d = shadow_q;
      dat_d    = dat_q;
      irq_d    = ie_q & ge;

      if (!en_q || stop || tick) pre_d = '0;
      else                       pre_d = pre_q + 16'd1;

      mtime_d = mtime_q + {63'd0, tick & ~stop};

      if (wr_en) begin
         case (addr)
            A_MTIME_LO: mtime_d = {mtime_q[63:32], byte_merge(mtime_q[31:0], wb_dat_i, wb_sel_i)};
            A_MTIME_HI: mtime_d = {byte_merge(mtime_q[63:32], wb_dat_i, wb_sel_i), mtime_q[31:0]};
            A_CMP_LO:   cmp_d   = {cmp_q[63:32], byte_merge(cmp_q[31:0], wb_dat_i, wb_sel_i)};
            A_CMP_HI:   cmp_d   = {byte_merge(cmp_q[63:32], wb_dat_i, wb_sel_i), cmp_q[31:0]};
            A_CTRL: begin
               if (wb_sel_i[0]) begin
                  en_d = wb_dat_i[0];
                  ie_d = wb_dat_i[1];
               end
            end
            default: ;
         endcase
      end

      if (rd_en) begin
         case (addr)
            A_MTIME_LO: begin
               dat_d    = mtime_q[31:0];
               shadow_d = mtime_q[63:32];
            end
            A_MTIME_HI: dat_d = shadow_q;
            A_CMP_LO:   dat_d = cmp_q[31:0];
            A_CMP_HI:   dat_d = cmp_q[63:32];
            A_CTRL:     dat_d = {30'd0, ie_q, en_q};
            A_STATUS:   dat_d = {31'd0, ge};
            default:    dat_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= S_IDLE;
         mtime_q  <= '0;
         cmp_q    <= '1;
         en_q     <= 1'b0;
         ie_q     <= 1'b0;
         pre_q    <= '0;
         shadow_q <= '0;
         dat_q    <= '0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mtime_q  <= mtime_d;
         cmp_q    <= cmp_d;
         en_q     <= en_d;
         ie_q     <= ie_d;
         pre_q    <= pre_d;
         shadow_q <= shadow_d;
         dat_q    <= dat_d;
         irq_q    <= irq_d;
      end
   end

   assign wb_ack_o    = (state_q == S_ACK);
   assign wb_dat_o    = dat_q;
   assign timer_irq_o = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32_wb_timer.sv
`default_nettype none
// tb_rv32_wb_timer: directed and random bus traffic against a cycle model of the timer.
module tb_rv32_wb_timer;
   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]  sel = '0;
   logic [31:0] adr = '0, wdat = '0;
   logic [31:0] rdat;
   logic        ack, irq;

   always #5 clk = ~clk;

   rv32_wb_timer #(.PRESCALE_DIV(DIV)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
      .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat),
      .wb_ack_o(ack), .timer_irq_o(irq)
   );

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   // Reference model: architectural registers advanced once per clock.
   logic [63:0] m_time = '0, m_cmp = '1, new_time;
   bit          m_en = 0, m_ie = 0, m_ack = 0, m_rdack = 0, m_irq = 0;
   int          m_pre = 0;
   logic [31:0] m_sh = '0, m_dat = '0;
   bit          acc, en_now, tick, ge;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_time = '0; m_cmp = '1; m_en = 0; m_ie = 0; m_pre = 0;
         m_sh = '0; m_dat = '0; m_ack = 0; m_rdack = 0; m_irq = 0;
      end else begin
         acc   = cyc && stb && !m_ack;
         ge    = (m_time >= m_cmp);
         m_irq = m_ie && ge;
         m_ack = acc;
         m_rdack = acc && !we;
         en_now = m_en;
         if (acc && we && adr[4:2] == 3'd4 && sel[0] && !wdat[0]) en_now = 0;
         tick = 0;
         if (en_now) begin
            tick  = (m_pre == DIV - 1);
            m_pre = (m_pre + 1) % DIV;
         end else m_pre = 0;
         new_time = m_time + (tick ? 64'd1 : 64'd0);
         if (acc && !we) begin
            case (adr[4:2])
               3'd0: begin m_dat = m_time[31:0]; m_sh = m_time[63:32]; end
               3'd1: m_dat = m_sh;
               3'd2: m_dat = m_cmp[31:0];
               3'd3: m_dat = m_cmp[63:32];
               3'd4: m_dat = {30'd0, m_ie, m_en};
               3'd5: m_dat = {31'd0, ge};
               default: m_dat = '0;
            endcase
         end
         if (acc && we) begin
            case (adr[4:2])
               3'd0: new_time = {m_time[63:32], merge(m_time[31:0], wdat, sel)};
               3'd1: new_time = {merge(m_time[63:32], wdat, sel), m_time[31:0]};
               3'd2: m_cmp = {m_cmp[63:32], merge(m_cmp[31:0], wdat, sel)};
               3'd3: m_cmp = {merge(m_cmp[63:32], wdat, sel), m_cmp[31:0]};
               3'd4: if (sel[0]) begin m_en = wdat[0]; m_ie = wdat[1]; end
               default: ;
            endcase
         end
         m_time = new_time;
      end
   end

   always @(negedge clk) begin
      chk("ack", ack, m_ack);
      if (m_rdack) chk("rdata", rdat, m_dat);
      chk("irq", irq, m_irq);
   end

   task automatic bus(input bit w, input logic [2:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] q, output int lat);
      cyc = 1; stb = 1; we = w; adr = {27'd0, a, 2'b00}; wdat = d; sel = s;
      lat = 0; q = '0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (ack) begin lat = i; q = rdat; break; end
      end
      cyc = 0; stb = 0; we = 0;
      if (lat == 0) chk("ack_timeout", 64'd0, 64'd1);
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] q);
      int lat;
      @(posedge clk); #1;
      bus(1'b0, a, 32'd0, 4'd0, q, lat);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] q;
      int lat;
      @(posedge clk); #1;
      bus(1'b1, a, d, s, q, lat);
   endtask

   function automatic logic [31:0] rst_val(input int a);
      return (a == 2 || a == 3) ? 32'hFFFF_FFFF : 32'h0;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] q, lo, hi;
      int          lat;
      bit          found;
      logic [5:0]  pat;

      repeat (3) @(negedge clk);
      rst_n = 1;

      for (int a = 0; a < 8; a++) begin
         @(posedge clk); #1;
         bus(1'b0, 3'(a), 32'd0, 4'd0, q, lat);
         chk($sformatf("reset_word%0d", a), q, rst_val(a));
         chk("ack_latency", lat, 2);
      end

      wr(3'd2, 32'h1122_3344, 4'hF);
      wr(3'd2, 32'hAABB_CCDD, 4'b0101);
      rd(3'd2, q);
      chk("byte_lanes", q, 32'h11BB_33DD);

      wr(3'd4, 32'd1, 4'hF);
      repeat (40) @(posedge clk);
      rd(3'd0, q);
      chk("prescale_count", (q >= 9 && q <= 11), 1);
      wr(3'd4, 32'd0, 4'hF);
      rd(3'd0, lo);
      repeat (100) @(posedge clk);
      rd(3'd0, hi);
      chk("frozen_when_disabled", hi, lo);

      wr(3'd3, 32'd0, 4'hF);
      wr(3'd2, 32'd20, 4'hF);
      wr(3'd4, 32'd3, 4'hF);
      found = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (irq) begin found = 1; break; end
      end
      chk("irq_rise_seen", found, 1);
      rd(3'd0, q);
      chk("irq_mtime_ge_20", (q >= 20), 1);
      wr(3'd2, 32'd1000, 4'hF);
      @(negedge clk);
      chk("irq_fall_after_cmp", irq, 0);
      wr(3'd2, 32'd0, 4'hF);
      wr(3'd4, 32'd1, 4'hF);
      repeat (10) @(negedge clk);
      chk("irq_masked", irq, 0);
      rd(3'd5, q);
      chk("status_ge", q, 1);

      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (m_pre == DIV - 1) break;
      end
      bus(1'b1, 3'd0, 32'h1234_5678, 4'hF, q, lat);
      rd(3'd0, q);
      chk("tick_write_wins", q, 32'h1234_5678);

      wr(3'd4, 32'd0, 4'hF);
      wr(3'd3, 32'd0, 4'hF);
      wr(3'd2, 32'd100, 4'hF);
      wr(3'd1, 32'hFFFF_FFFF, 4'hF);
      wr(3'd0, 32'hFFFF_FFFE, 4'hF);
      rd(3'd5, q);
      chk("status_before_wrap", q, 1);
      wr(3'd4, 32'd1, 4'hF);
      rd(3'd0, lo);
      rd(3'd1, hi);
      chk("shadow_consistent", hi, (lo >= 32'hFFFF_FFFE) ? 32'hFFFF_FFFF : 32'h0);
      repeat (20) @(posedge clk);
      rd(3'd0, lo);
      rd(3'd1, hi);
      chk("wrap_hi", hi, 0);
      chk("wrap_lo_small", (lo < 100), 1);
      rd(3'd5, q);
      chk("status_after_wrap", q, 0);

      @(posedge clk); #1;
      cyc = 1; stb = 1; we = 0; adr = 32'h10; sel = 4'h0;
      pat = '0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         pat[i] = ack;
      end
      cyc = 0; stb = 0;
      chk("back_to_back", pat, 6'b101010);

      for (int i = 0; i < 80; i++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         @(posedge clk); #1;
         bus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
             4'($urandom_range(0, 15)), q, lat);
      end

      @(posedge clk); #1;
      cyc = 1; stb = 1; we = 1; adr = 32'h10; wdat = 32'd3; sel = 4'hF;
      @(negedge clk);
      @(negedge clk);
      chk("abort_ack_high", ack, 1);
      #2 rst_n = 0;
      #1 chk("abort_ack_drop", ack, 0);
      cyc = 0; stb = 0; we = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      rd(3'd4, q);
      chk("abort_ctrl_reset", q, 0);
      rd(3'd2, q);
      chk("abort_cmp_reset", q, 32'hFFFF_FFFF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
